load_receiver: RTL and testbench

- Processor-side receiver for the program-load interface: new_instruction, add_into, start_signal in; end_signal back from the core.
- Writes the incoming word stream first into instruction memory, then into data memory.
- Arms and releases the core (cpu_run) on start_signal, and parks it on end_signal.
- Sits between the external loader and the processor's instruction and data memories.

---
 rtl/load_receiver.sv | 148 ++++++++++++++
 tb/tb_load_receiver.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/load_receiver.sv
// Program-load receiver: streams words into instruction then data memory,
// then arms, runs and parks the core via cpu_run.
module load_receiver #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 6,
  parameter int IMEM_DEPTH = 64,
  parameter int DMEM_DEPTH = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] new_instruction,
  input  logic              in_valid,
  input  logic              add_into,
  input  logic              start_signal,
  input  logic              end_signal,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic [ADDR_W:0]   imem_count,
  output logic [ADDR_W:0]   dmem_count,
  output logic              cpu_run,
  output logic [1:0]        state,
  output logic [1:0]        err
);

  typedef enum logic [1:0] {
    ST_LOAD = 2'b00,
    ST_ARM  = 2'b01,
    ST_RUN  = 2'b10,
    ST_HALT = 2'b11
  } state_t;

  localparam logic [ADDR_W:0] ICAP = (ADDR_W+1)'(IMEM_DEPTH);
  localparam logic [ADDR_W:0] DCAP = (ADDR_W+1)'(DMEM_DEPTH);

  state_t              state_q, state_d;
  logic                phase_q, phase_d;
  logic                imem_we_q, imem_we_d;
  logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
  logic [DATA_W-1:0]   imem_wdata_q, imem_wdata_d;
  logic                dmem_we_q, dmem_we_d;
  logic [ADDR_W-1:0]   dmem_addr_q, dmem_addr_d;
  logic [DATA_W-1:0]   dmem_wdata_q, dmem_wdata_d;
  logic [ADDR_W:0]     imem_count_q, imem_count_d;
  logic [ADDR_W:0]     dmem_count_q, dmem_count_d;
  logic                cpu_run_q, cpu_run_d;
  logic [1:0]          err_q, err_d;

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    dmem_we_d    = 1'b0;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    imem_count_d = imem_count_q;
    dmem_count_d = dmem_count_q;
    err_d        = err_q;

    case (state_q)
      ST_LOAD: begin
        if (in_valid) begin
          // Once any data word is seen, the stream never returns to imem.
          if (phase_q || add_into) begin
            phase_d = 1'b1;
            if (dmem_count_q == DCAP) begin
              err_d[0] = 1'b1;
            end else begin
              dmem_we_d    = 1'b1;
              dmem_addr_d  = dmem_count_q[ADDR_W-1:0];
              dmem_wdata_d = new_instruction;
              dmem_count_d = dmem_count_q + 1'b1;
            end
          end else if (imem_count_q == ICAP) begin
            err_d[0] = 1'b1;
          end else begin
            imem_we_d    = 1'b1;
            imem_addr_d  = imem_count_q[ADDR_W-1:0];
            imem_wdata_d = new_instruction;
            imem_count_d = imem_count_q + 1'b1;
          end
        end
        if (start_signal) begin
          if (imem_count_d == '0) begin
            state_d  = ST_HALT;
            err_d[1] = 1'b1;
          end else begin
            state_d = ST_ARM;
          end
        end
      end
      // ARM lets the final write strobe land before the core starts.
      ST_ARM:  state_d = ST_RUN;
      ST_RUN:  if (end_signal) state_d = ST_HALT;
      default: state_d = ST_HALT;
    endcase

    cpu_run_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_LOAD;
      phase_q      <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      imem_count_q <= '0;
      dmem_count_q <= '0;
      cpu_run_q    <= 1'b0;
      err_q        <= 2'b00;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      imem_count_q <= imem_count_d;
      dmem_count_q <= dmem_count_d;
      cpu_run_q    <= cpu_run_d;
      err_q        <= err_d;
    end
  end

  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;
  assign imem_count = imem_count_q;
  assign dmem_count = dmem_count_q;
  assign cpu_run    = cpu_run_q;
  assign state      = state_q;
  assign err        = err_q;

endmodule

// File: tb/tb_load_receiver.sv
// Scoreboard bench for load_receiver: expected memory writes are queued as
// words are driven and matched against the write strobes as they appear.
module tb_load_receiver;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 6;
  localparam int IDEPTH = 64;
  localparam int DDEPTH = 64;

  logic              clk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] new_instruction;
  logic              in_valid, add_into, start_signal, end_signal;
  logic              imem_we, dmem_we, cpu_run;
  logic [ADDR_W-1:0] imem_addr, dmem_addr;
  logic [DATA_W-1:0] imem_wdata, dmem_wdata;
  logic [ADDR_W:0]   imem_count, dmem_count;
  logic [1:0]        state, err;

  load_receiver #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .IMEM_DEPTH(IDEPTH), .DMEM_DEPTH(DDEPTH)
  ) dut (
    .clk(clk), .reset(reset), .new_instruction(new_instruction),
    .in_valid(in_valid), .add_into(add_into), .start_signal(start_signal),
    .end_signal(end_signal), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .imem_count(imem_count), .dmem_count(dmem_count),
    .cpu_run(cpu_run), .state(state), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    int                cyc;
  } wr_t;

  wr_t imem_q[$];
  wr_t dmem_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  cyc      = 0;
  bit  run_seen = 1'b0;

  // model of the load phase
  bit  m_load;
  bit  m_phase;
  int  m_ic, m_dc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (cpu_run) run_seen = 1'b1;
      if (imem_we || dmem_we) check("we_exclusive", {63'd0, imem_we & dmem_we}, 64'd0);
      if (imem_we) begin
        check("imem_strobe_expected", {63'd0, imem_q.size() > 0}, 64'd1);
        if (imem_q.size() > 0) begin
          wr_t e;
          e = imem_q.pop_front();
          check("imem_addr", 64'(imem_addr), 64'(e.addr));
          check("imem_wdata", 64'(imem_wdata), 64'(e.data));
          check("imem_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
      if (dmem_we) begin
        check("dmem_strobe_expected", {63'd0, dmem_q.size() > 0}, 64'd1);
        if (dmem_q.size() > 0) begin
          wr_t e;
          e = dmem_q.pop_front();
          check("dmem_addr", 64'(dmem_addr), 64'(e.addr));
          check("dmem_wdata", 64'(dmem_wdata), 64'(e.data));
          check("dmem_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
    end
  end

  // Drive one cycle of inputs; returns #1 after the sampling edge.
  task automatic step(input bit v, input logic [DATA_W-1:0] w, input bit a,
                      input bit st, input bit en);
    wr_t e;
    in_valid = v; new_instruction = w; add_into = a;
    start_signal = st; end_signal = en;
    if (m_load && v) begin
      e.data = w;
      e.cyc  = cyc + 1;
      if (m_phase || a) begin
        m_phase = 1'b1;
        if (m_dc < DDEPTH) begin
          e.addr = ADDR_W'(m_dc); dmem_q.push_back(e); m_dc++;
        end
      end else if (m_ic < IDEPTH) begin
        e.addr = ADDR_W'(m_ic); imem_q.push_back(e); m_ic++;
      end
    end
    if (m_load && st) m_load = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0; add_into = 1'b0; start_signal = 1'b0; end_signal = 1'b0;
    new_instruction = '0;
  endtask

  task automatic do_reset(input string tag);
    #2 reset = 1'b1;
    #2;
    check({tag, "_state"}, 64'(state), 64'd0);
    check({tag, "_outs"}, {imem_we, dmem_we, cpu_run, err, imem_count, dmem_count,
                           imem_addr, dmem_addr}, 64'd0);
    check({tag, "_wdata"}, {imem_wdata, dmem_wdata}, 64'd0);
    check({tag, "_q_drained"}, 64'(imem_q.size() + dmem_q.size()), 64'd0);
    imem_q.delete(); dmem_q.delete();
    m_load = 1'b1; m_phase = 1'b0; m_ic = 0; m_dc = 0; run_seen = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; add_into = 1'b0; start_signal = 1'b0; end_signal = 1'b0;
    new_instruction = '0;
    m_load = 1'b1; m_phase = 1'b0; m_ic = 0; m_dc = 0;
    @(posedge clk); #1;

    // basic load: 3 instructions, 2 data words, start
    do_reset("rst1");
    for (int i = 0; i < 3; i++) step(1, 32'h1000 + i, 0, 0, 0);
    for (int i = 0; i < 2; i++) step(1, 32'h2000 + i, 1, 0, 0);
    step(0, '0, 0, 1, 0);
    check("t1_imem_count", 64'(imem_count), 64'd3);
    check("t1_dmem_count", 64'(dmem_count), 64'd2);
    check("t1_arm", 64'(state), 64'd1);
    check("t1_arm_run", 64'(cpu_run), 64'd0);
    step(1, 32'h5555, 0, 1, 0);      // ignored in RUN
    check("t1_run", 64'(state), 64'd2);
    check("t1_cpu_run", 64'(cpu_run), 64'd1);
    step(0, '0, 0, 0, 0);
    check("t1_run_hold", 64'(state), 64'd2);
    check("t1_icount_run", 64'(imem_count), 64'd3);

    // data phase is sticky; end_signal ignored in LOAD
    do_reset("rst2");
    step(1, 32'hA0, 1, 0, 0);
    step(1, 32'hA1, 0, 0, 1);
    step(0, '0, 0, 0, 0);
    check("t2_imem_count", 64'(imem_count), 64'd0);
    check("t2_dmem_count", 64'(dmem_count), 64'd2);
    check("t2_state", 64'(state), 64'd0);

    // imem overflow, then loading continues into dmem
    do_reset("rst3");
    for (int i = 0; i < IDEPTH + 1; i++) step(1, $urandom, 0, 0, 0);
    step(0, '0, 0, 0, 0);
    check("t3_imem_count", 64'(imem_count), 64'(IDEPTH));
    check("t3_err", 64'(err), 64'd1);
    step(1, 32'hD00D, 1, 0, 0);
    step(0, '0, 0, 0, 0);
    check("t3_dmem_count", 64'(dmem_count), 64'd1);
    check("t3_err_sticky", 64'(err), 64'd1);

    // start with same-cycle word, then end_signal and HALT
    do_reset("rst4");
    step(1, 32'hDEADBEEF, 0, 1, 0);
    check("t4_strobe", 64'(imem_we), 64'd1);
    check("t4_arm", 64'(state), 64'd1);
    check("t4_arm_run", 64'(cpu_run), 64'd0);
    step(0, '0, 0, 1, 0);
    check("t4_run", 64'(state), 64'd2);
    check("t4_cpu_run", 64'(cpu_run), 64'd1);
    step(0, '0, 0, 0, 1);
    check("t4_halt", 64'(state), 64'd3);
    check("t4_halt_run", 64'(cpu_run), 64'd0);
    step(1, 32'h77, 0, 1, 0);
    step(0, '0, 0, 0, 1);
    check("t4_halt_hold", 64'(state), 64'd3);
    check("t4_halt_icount", 64'(imem_count), 64'd1);

    // empty-program start
    do_reset("rst5");
    step(0, '0, 0, 1, 0);
    check("t5_state", 64'(state), 64'd3);
    check("t5_err", 64'(err), 64'd2);
    for (int i = 0; i < 4; i++) step(1, 32'h9, 0, 1, 0);
    check("t5_never_ran", {63'd0, run_seen}, 64'd0);
    check("t5_err_hold", 64'(err), 64'd2);

    do_reset("rst_end");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
